// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU requests into word-aligned data_memory
// accesses, with lane extraction on loads and read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] endereco,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic        done,
  output logic [31:0] read_data,
  output logic        erro,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_endereco,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  // state | meaning
  // IDLE  | ready, waiting for req
  // LOAD  | memory read, extract and extend lane
  // ST_RD | sub-word store: read word into merge register
  // ST_WR | memory write
  // RESP  | done pulse, erro valid
  typedef enum logic [2:0] {IDLE, LOAD, ST_RD, ST_WR, RESP} state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_t      state, state_nx;
  logic        rd_q, wr_q, sx_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val, merged;

  always_comb begin
    req_err = (MemRead == MemWrite)
           || (size == 2'b11)
           || (size == 2'b01 && endereco[0])
           || (size == 2'b10 && endereco[1:0] != 2'b00)
           || ({1'b0, endereco} >= ADDR_LIMIT);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (req_err)             state_nx = RESP;
          else if (MemRead)        state_nx = LOAD;
          else if (size == 2'b10)  state_nx = ST_WR;
          else                     state_nx = ST_RD;
        end
      end
      LOAD:    state_nx = RESP;
      ST_RD:   state_nx = ST_WR;
      ST_WR:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Little-endian lane selection shared by the load path and the store merge
  always_comb begin
    lane_b = mem_read_data[7:0];
    unique case (addr_q[1:0])
      2'd0: lane_b = mem_read_data[7:0];
      2'd1: lane_b = mem_read_data[15:8];
      2'd2: lane_b = mem_read_data[23:16];
      2'd3: lane_b = mem_read_data[31:24];
      default: lane_b = mem_read_data[7:0];
    endcase
    lane_h = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    unique case (size_q)
      2'b00:   load_val = {{24{sx_q & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{sx_q & lane_h[15]}}, lane_h};
      default: load_val = mem_read_data;
    endcase
  end

  always_comb begin
    merged = merge_q;
    if (size_q == 2'b00) begin
      unique case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = merge_q;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      sx_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        rd_q    <= MemRead;
        wr_q    <= MemWrite;
        sx_q    <= sign_ext;
        size_q  <= size;
        addr_q  <= endereco;
        wdata_q <= write_data;
        err_q   <= req_err;
      end
      if (state == LOAD && rd_q) rdata_q <= load_val;
      if (state == ST_RD)        merge_q <= mem_read_data;
    end
  end

  // Memory strobes depend on state alone so an async reset kills them at once
  always_comb begin
    ready          = (state == IDLE);
    done           = (state == RESP);
    erro           = (state == RESP) && err_q;
    read_data      = rdata_q;
    mem_read       = (state == LOAD) || (state == ST_RD);
    mem_write      = (state == ST_WR);
    mem_endereco   = {addr_q[31:2], 2'b00};
    mem_write_data = '0;
    if (state == ST_WR && wr_q)
      mem_write_data = (size_q == 2'b10) ? wdata_q : merged;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU datapath and the word-addressed data_memory.
- Accepts byte, halfword and word load/store requests and produces word-aligned memory accesses.
- Loads: extracts the selected lane and sign- or zero-extends it.
- Sub-word stores: read-modify-write sequence (read word, merge lane, write word). Reports misaligned and out-of-range accesses instead of issuing them.

Parameters:
- MEM_WORDS, 256: depth of the attached data memory in 32-bit words. Byte addresses >= MEM_WORDS*4 are out of range.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req  input  1  request strobe; accepted only when ready=1
- MemRead  input  1  request is a load
- MemWrite  input  1  request is a store
- size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- sign_ext  input  1  loads: 1 sign-extend, 0 zero-extend
- endereco  input  32  byte address
- write_data  input  32  store data; byte in [7:0], half in [15:0]
- ready  output  1  unit idle, can accept req
- done  output  1  one-cycle completion pulse
- read_data  output  32  load result; held until the next load completes
- erro  output  1  valid with done: request rejected, no memory write issued
- mem_read  output  1  to data_memory MemRead
- mem_write  output  1  to data_memory MemWrite
- mem_endereco  output  32  to data_memory endereco, always {addr[31:2],2'b00}
- mem_write_data  output  32  to data_memory write_data
- mem_read_data  input  32  from data_memory read_data (combinational)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; ready=1; done=0; erro=0; read_data=0; mem_read=0; mem_write=0; mem_endereco=0; mem_write_data=0; all latched request fields cleared.
- mem_read and mem_write are decoded from state only, so reset mid-operation drops them immediately and no write is issued after reset asserts.
- Endianness is little-endian:
  - Byte lane k = addr[1:0] maps to bits [8k+7:8k].
  - Halfword lane addr[1] maps to bits [16*addr[1]+15:16*addr[1]].
- Acceptance: in IDLE with req=1, latch MemRead, MemWrite, size, sign_ext, endereco and write_data. ready=0 in every state except IDLE. req outside IDLE is ignored.
- Error check at acceptance. Any of the following go to RESP with erro=1 and no memory access:
  - MemRead and MemWrite both 1, or both 0.
  - size=11.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr >= MEM_WORDS*4.
- States and transitions:
  - IDLE -> LOAD, ST_RD or ST_WR on a valid req; -> RESP on an error.
  - LOAD, one cycle: mem_read=1. At the clock edge, capture the lane from mem_read_data, extend it, and write read_data. -> RESP.
  - ST_RD, one cycle (byte or half stores only): mem_read=1. Capture mem_read_data into the merge register. -> ST_WR.
  - ST_WR, one cycle: mem_write=1.
    - mem_write_data = write_data for word stores.
    - Otherwise, the merge register with only the target lane replaced.
    - data_memory commits on this edge. -> RESP.
  - RESP, one cycle: done=1; erro as determined. -> IDLE (ready=1 next cycle).
- Latency from the accepting edge to the done pulse:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Byte/half store: 3 cycles.
  - Error: 1 cycle.
- mem_read=0 in every state except LOAD and ST_RD. mem_write=0 in every state except ST_WR. Both are never 1 in the same cycle.
- read_data is unchanged by stores and errors.
- erro is 0 whenever done is 0.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF, then load word at 0x10 -> mem_write pulses once with mem_endereco=0x10; load done after 2 cycles with read_data=0xDEADBEEF, erro=0.
- Byte store merge: memory[0x20]=0x11223344, store byte 0xAA at 0x22 -> ST_RD, ST_WR sequence writes 0x11AA3344; done 3 cycles after accept.
- Sign/zero extension: memory[0x30]=0x80F0_7F85.
  - Load byte at 0x30 with sign_ext=1 -> 0xFFFFFF85.
  - Same with sign_ext=0 -> 0x00000085.
  - Load half at 0x32 with sign_ext=1 -> 0xFFFF80F0.
- Misaligned and out-of-range: word load at 0x06, half store at 0x11, word load at 0x400 (MEM_WORDS=256) -> each gives done=1 with erro=1 one cycle after accept; mem_write never asserts; read_data unchanged.
- Busy handling: hold req=1 continuously while a byte store is in progress -> ready=0 for 3 cycles; the second request is accepted only on the cycle after done.
- Reset mid-operation: assert reset_n=0 during ST_RD of a halfword store -> mem_read and mem_write go to 0 immediately; memory contents unchanged; ready=1 after release; a subsequent word load completes normally.
